// File: rtl/gate_pkg.sv
// Shared encodings, state type and golden gate model for the gate self-check sequencer.
package gate_pkg;

    localparam logic [2:0] OP_BUF  = 3'd0;
    localparam logic [2:0] OP_NOT  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_NAND = 3'd4;
    localparam logic [2:0] OP_NOR  = 3'd5;
    localparam logic [2:0] OP_XOR  = 3'd6;
    localparam logic [2:0] OP_XNOR = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Single-input ops (BUF/NOT) ignore b entirely.
    function automatic logic golden(input logic [2:0] op, input logic a, input logic b);
        logic y;
        case (op)
            OP_BUF:  y = a;
            OP_NOT:  y = ~a;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XOR:  y = a ^ b;
            default: y = ~(a ^ b);
        endcase
        return y;
    endfunction

endpackage

// File: rtl/gate_golden.sv
// Combinational reference model of the selected 2-input gate.
module gate_golden
    import gate_pkg::*;
(
    input  logic [2:0] op_i,
    input  logic       a_i,
    input  logic       b_i,
    output logic       y_o
);

    assign y_o = golden(op_i, a_i, b_i);

endmodule

// File: rtl/gate_check_sequencer.sv
// Sweeps all four input vectors through an external gate, compares each settled
// output with the golden model and reports pass/fail counts and the first failing vector.
module gate_check_sequencer
    import gate_pkg::*;
#(
    parameter int SETTLE_CYC = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] op_sel,
    output logic       dut_a,
    output logic       dut_b,
    input  logic       dut_y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] pass_count,
    output logic [2:0] fail_count,
    output logic [1:0] first_fail,
    output logic [1:0] dbg_state
);

    localparam logic [3:0] TIMER_LOAD = 4'(SETTLE_CYC - 1);

    state_e      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [1:0]  vec_q, vec_d;
    logic [3:0]  timer_q, timer_d;
    logic [2:0]  pass_cnt_q, pass_cnt_d;
    logic [2:0]  fail_cnt_q, fail_cnt_d;
    logic [1:0]  first_fail_q, first_fail_d;
    logic        pass_q, pass_d;
    logic        exp_y;

    gate_golden u_golden (
        .op_i (op_q),
        .a_i  (vec_q[0]),
        .b_i  (vec_q[1]),
        .y_o  (exp_y)
    );

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        vec_d        = vec_q;
        timer_d      = timer_q;
        pass_cnt_d   = pass_cnt_q;
        fail_cnt_d   = fail_cnt_q;
        first_fail_d = first_fail_q;
        pass_d       = pass_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d         = op_sel;
                    vec_d        = 2'd0;
                    timer_d      = TIMER_LOAD;
                    pass_cnt_d   = 3'd0;
                    fail_cnt_d   = 3'd0;
                    first_fail_d = 2'd0;
                    pass_d       = 1'b0;
                    state_d      = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (timer_q == 4'd0) begin
                    state_d = ST_CHECK;
                end else begin
                    timer_d = timer_q - 4'd1;
                end
            end
            ST_CHECK: begin
                if (exp_y == dut_y) begin
                    pass_cnt_d = pass_cnt_q + 3'd1;
                end else begin
                    fail_cnt_d = fail_cnt_q + 3'd1;
                    if (fail_cnt_q == 3'd0) begin
                        first_fail_d = vec_q;
                    end
                end
                if (vec_q == 2'd3) begin
                    // Final verdict is folded in here so it is ready alongside done.
                    pass_d  = (fail_cnt_q == 3'd0) && (exp_y == dut_y);
                    state_d = ST_DONE;
                end else begin
                    vec_d   = vec_q + 2'd1;
                    timer_d = TIMER_LOAD;
                    state_d = ST_SETTLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            op_q         <= 3'd0;
            vec_q        <= 2'd0;
            timer_q      <= 4'd0;
            pass_cnt_q   <= 3'd0;
            fail_cnt_q   <= 3'd0;
            first_fail_q <= 2'd0;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            vec_q        <= vec_d;
            timer_q      <= timer_d;
            pass_cnt_q   <= pass_cnt_d;
            fail_cnt_q   <= fail_cnt_d;
            first_fail_q <= first_fail_d;
            pass_q       <= pass_d;
        end
    end

    // Gate inputs come straight from the vector register, so they change only on a clock edge.
    assign dut_a      = vec_q[0];
    assign dut_b      = vec_q[1];
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign pass       = pass_q;
    assign pass_count = pass_cnt_q;
    assign fail_count = fail_cnt_q;
    assign first_fail = first_fail_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_gate_check_sequencer.sv
// Self-checking bench for gate_check_sequencer with an expected-result scoreboard.
module tb_gate_check_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start = 1'b0;
    logic [2:0] op_sel = 3'd0;
    logic       dut_a, dut_b, dut_y;
    logic       busy, done, pass;
    logic [2:0] pass_count, fail_count;
    logic [1:0] first_fail, dbg_state;
    logic [3:0] gate_tt = 4'b0000;

    logic       start2 = 1'b0;
    logic [2:0] op_sel2 = 3'd0;
    logic       dut_a2, dut_b2, dut_y2;
    logic       busy2, done2, pass2;
    logic [2:0] pass_count2, fail_count2;
    logic [1:0] first_fail2, dbg_state2;
    logic [3:0] gate_tt2 = 4'b0000;

    logic [2:0] g_op = 3'd0;
    logic       g_a = 1'b0, g_b = 1'b0, g_y;

    int checks = 0;
    int failures = 0;
    logic [8:0] exp_q[$];

    always #5 clk = ~clk;

    // The gate under test is a truth table indexed by {b, a}.
    assign dut_y  = gate_tt[{dut_b, dut_a}];
    assign dut_y2 = gate_tt2[{dut_b2, dut_a2}];

    gate_check_sequencer #(.SETTLE_CYC(2)) u_dut (
        .clk(clk), .rst(rst), .start(start), .op_sel(op_sel),
        .dut_a(dut_a), .dut_b(dut_b), .dut_y(dut_y),
        .busy(busy), .done(done), .pass(pass),
        .pass_count(pass_count), .fail_count(fail_count),
        .first_fail(first_fail), .dbg_state(dbg_state)
    );

    gate_check_sequencer #(.SETTLE_CYC(1)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .op_sel(op_sel2),
        .dut_a(dut_a2), .dut_b(dut_b2), .dut_y(dut_y2),
        .busy(busy2), .done(done2), .pass(pass2),
        .pass_count(pass_count2), .fail_count(fail_count2),
        .first_fail(first_fail2), .dbg_state(dbg_state2)
    );

    gate_golden u_ref (.op_i(g_op), .a_i(g_a), .b_i(g_b), .y_o(g_y));

    function automatic logic [3:0] tt(input logic [2:0] op);
        case (op)
            3'd0:    return 4'b1010;
            3'd1:    return 4'b0101;
            3'd2:    return 4'b1000;
            3'd3:    return 4'b1110;
            3'd4:    return 4'b0111;
            3'd5:    return 4'b0001;
            3'd6:    return 4'b0110;
            default: return 4'b1001;
        endcase
    endfunction

    // Packed as {pass, pass_count, fail_count, first_fail}.
    function automatic logic [8:0] expect_result(input logic [2:0] op, input logic [3:0] model);
        logic [3:0] ref_tt;
        logic [2:0] pc, fc;
        logic [1:0] ff;
        ref_tt = tt(op);
        pc = 3'd0;
        fc = 3'd0;
        ff = 2'd0;
        for (int v = 0; v < 4; v++) begin
            if (ref_tt[v] == model[v]) begin
                pc = pc + 3'd1;
            end else begin
                if (fc == 3'd0) ff = 2'(v);
                fc = fc + 3'd1;
            end
        end
        return {fc == 3'd0, pc, fc, ff};
    endfunction

    task automatic sweep1(input logic [2:0] op, input logic [3:0] model, input bit disturb, input string name);
        int done_at;
        int pulses;
        logic [8:0] exp;
        logic [8:0] got;
        exp = 9'd0;
        done_at = -1;
        pulses = 0;
        op_sel = op;
        gate_tt = model;
        start = 1'b1;
        exp_q.push_back(expect_result(op, model));
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL %s busy_after_start got=%b exp=1", name, busy);
        end
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (disturb) begin
                if (k == 3) op_sel = ~op;
                if (k == 4) start = 1'b1;
                if (k == 5) start = 1'b0;
            end
            if (done === 1'b1) begin
                pulses++;
                if (done_at < 0) begin
                    done_at = k;
                    got = {pass, pass_count, fail_count, first_fail};
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL %s unexpected_done got=%h exp=none", name, got);
                    end else begin
                        exp = exp_q.pop_front();
                        if (got !== exp) begin
                            failures++;
                            $display("FAIL %s result got=%h exp=%h", name, got, exp);
                        end
                    end
                end
            end
            if (k == 13) begin
                checks++;
                if (busy !== 1'b0) begin
                    failures++;
                    $display("FAIL %s busy_after_done got=%b exp=0", name, busy);
                end
            end
        end
        checks++;
        if (done_at != 12) begin
            failures++;
            $display("FAIL %s done_latency got=%0d exp=12", name, done_at);
        end
        checks++;
        if (pulses != 1) begin
            failures++;
            $display("FAIL %s done_pulses got=%0d exp=1", name, pulses);
        end
        checks++;
        got = {pass, pass_count, fail_count, first_fail};
        if (done_at > 0 && got !== exp) begin
            failures++;
            $display("FAIL %s result_hold got=%h exp=%h", name, got, exp);
        end
        while (exp_q.size() > 0) begin
            failures++;
            $display("FAIL %s missing_done got=none exp=%h", name, exp_q.pop_front());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({dbg_state, dut_a, dut_b, busy, done, pass, pass_count, fail_count, first_fail} !== 15'd0) begin
            failures++;
            $display("FAIL reset_dut1 got=%h exp=0",
                     {dbg_state, dut_a, dut_b, busy, done, pass, pass_count, fail_count, first_fail});
        end
        checks++;
        if ({dbg_state2, dut_a2, dut_b2, busy2, done2, pass2, pass_count2, fail_count2, first_fail2} !== 15'd0) begin
            failures++;
            $display("FAIL reset_dut2 got=%h exp=0",
                     {dbg_state2, dut_a2, dut_b2, busy2, done2, pass2, pass_count2, fail_count2, first_fail2});
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_golden();
        for (int op = 0; op < 8; op++) begin
            for (int v = 0; v < 4; v++) begin
                logic [3:0] row;
                row = tt(3'(op));
                g_op = 3'(op);
                g_a = v[0];
                g_b = v[1];
                #1;
                checks++;
                if (g_y !== row[v]) begin
                    failures++;
                    $display("FAIL golden op=%0d vec=%0d got=%b exp=%b", op, v, g_y, row[v]);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        op_sel = 3'd1;
        gate_tt = tt(3'd1);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        checks++;
        if (dbg_state !== 2'd2 || dut_a !== 1'b1 || dut_b !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_pre state=%0d a=%b b=%b exp state=2 a=1 b=0", dbg_state, dut_a, dut_b);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({dbg_state, dut_a, dut_b, busy, done, pass, pass_count, fail_count, first_fail} !== 15'd0) begin
            failures++;
            $display("FAIL mid_reset_clear got=%h exp=0",
                     {dbg_state, dut_a, dut_b, busy, done, pass, pass_count, fail_count, first_fail});
        end
        sweep1(3'd1, tt(3'd1), 1'b0, "after_reset");
    endtask

    task automatic test_back_to_back();
        int done_cnt;
        logic [8:0] exp;
        logic [8:0] got;
        done_cnt = 0;
        op_sel = 3'd2;
        gate_tt = 4'b1001;
        start = 1'b1;
        exp_q.push_back(expect_result(3'd2, 4'b1001));
        exp_q.push_back(expect_result(3'd2, 4'b1001));
        @(posedge clk); #1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (k == 14) start = 1'b0;
            if (k == 13 || k == 14) begin
                checks++;
                if (busy !== (k == 14)) begin
                    failures++;
                    $display("FAIL b2b_busy k=%0d got=%b exp=%b", k, busy, (k == 14));
                end
            end
            if (done === 1'b1) begin
                done_cnt++;
                got = {pass, pass_count, fail_count, first_fail};
                checks++;
                if ((k != 12 && k != 26) || exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL b2b_done_time got=%0d exp=12_or_26", k);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        failures++;
                        $display("FAIL b2b_result got=%h exp=%h", got, exp);
                    end
                end
            end
        end
        checks++;
        if (done_cnt != 2) begin
            failures++;
            $display("FAIL b2b_done_count got=%0d exp=2", done_cnt);
        end
        exp_q.delete();
    endtask

    task automatic test_settle1();
        int done_at;
        logic [8:0] exp;
        logic [8:0] got;
        done_at = -1;
        op_sel2 = 3'd4;
        gate_tt2 = tt(3'd4);
        exp = expect_result(3'd4, tt(3'd4));
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            @(posedge clk); #1;
            if (done2 === 1'b1 && done_at < 0) begin
                done_at = k;
                got = {pass2, pass_count2, fail_count2, first_fail2};
                checks++;
                if (got !== exp || pass2 !== 1'b1) begin
                    failures++;
                    $display("FAIL settle1_result got=%h exp=%h", got, exp);
                end
            end
        end
        checks++;
        if (done_at != 8) begin
            failures++;
            $display("FAIL settle1_latency got=%0d exp=8", done_at);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 4; i++) begin
            logic [2:0] op;
            logic [3:0] model;
            op = 3'($urandom_range(0, 7));
            model = 4'($urandom_range(0, 15));
            sweep1(op, model, 1'b0, "random");
        end
    endtask

    initial begin
        test_reset();
        test_golden();
        sweep1(3'd1, tt(3'd1), 1'b0, "not_pass");
        sweep1(3'd1, 4'b0000, 1'b0, "not_stuck0");
        sweep1(3'd6, tt(3'd3), 1'b0, "xor_vs_or");
        test_mid_reset();
        sweep1(3'd5, tt(3'd5), 1'b1, "restart_ignored");
        test_back_to_back();
        test_settle1();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gate_check_sequencer.md
# gate_check_sequencer

Sequential controller that exercises one 2-input combinational gate (e.g. `logic_not`, `logic_and`) in hardware. On `start` it sweeps all four input combinations and waits a programmable settle time per vector. It compares the gate output against a built-in golden model of the selected operation and reports pass/fail counts. It sits between a board-level start button/switch bank and any single gate instance, so the gate library can be self-checked on the FPGA without a simulator.

## Interface
Parameters:
- `SETTLE_CYC`, default 2: cycles each vector is held before the output is sampled. Legal range is 1..15.

Ports:
- `clk` input, 1 bit: single clock. All logic is on the rising edge.
- `rst` input, 1 bit: reset, synchronous and active-high.
- `start` input, 1 bit: begin a sweep. Sampled only in IDLE.
- `op_sel` input, 3 bits: gate under test. Encodings are listed under Structure.
- `dut_a` output, 1 bit: gate input A, registered.
- `dut_b` output, 1 bit: gate input B, registered. The value is don't-care for BUF/NOT but is still swept.
- `dut_y` input, 1 bit: gate output, sampled in CHECK.
- `busy` output, 1 bit: high from the cycle after `start` is accepted until DONE is exited.
- `done` output, 1 bit: one-cycle pulse at the end of a sweep.
- `pass` output, 1 bit: high when `fail_count == 0`. Valid from `done` until the next accepted `start`.
- `pass_count` output, 3 bits: number of vectors that matched (0..4).
- `fail_count` output, 3 bits: number of vectors that mismatched (0..4).
- `first_fail` output, 2 bits: index of the first mismatching vector. Holds 0 when there were no fails.

## Operation
- Vector index `vec` is 2 bits. The sequencer drives `dut_a = vec[0]` and `dut_b = vec[1]`. The sweep order is vec 0, 1, 2, 3.
- States are IDLE, SETTLE, CHECK and DONE.
- IDLE:
  - With `start` high, on the next edge: latch `op_sel` into `op_q`.
  - On the same edge: clear `vec`, the counts and `first_fail`, and drive `dut_a`/`dut_b` to 0.
  - On the same edge: load timer with `SETTLE_CYC-1` and go to SETTLE.
- SETTLE: decrement the timer. When the timer is 0, go to CHECK.
- CHECK:
  - Compute `exp = golden(op_q, a, b)` and compare it with `dut_y`.
  - On a match, increment `pass_count`.
  - On a mismatch, increment `fail_count`. If this is the first fail, set `first_fail = vec`.
  - If `vec == 3`, go to DONE.
  - Otherwise, increment `vec`, register the new `dut_a`/`dut_b`, reload the timer and go to SETTLE.
- DONE: assert `done` for one cycle, then go to IDLE. The results hold until the next accepted `start`.
- `op_sel` changes after acceptance are ignored, because only `op_q` is used.
- `start` is ignored while `busy`. A `start` held high in DONE is not seen until IDLE, which starts a new sweep on the following edge.
- Reset (including mid-sweep) does the following on the edge:
  - state goes to IDLE;
  - all outputs go to 0, including `dut_a`/`dut_b`, `busy`, `done`, `pass`, the counts and `first_fail`;
  - the partial results of the interrupted sweep are discarded.
- Counts never exceed 4, and `pass_count + fail_count == 4` at `done`.

## Timing
- Start acceptance is at edge E0, where `start` is high in IDLE. `busy` rises after E0.
- Each vector occupies `SETTLE_CYC` SETTLE cycles plus 1 CHECK cycle.
- `done` is high in the cycle after edge E0 + 4·(`SETTLE_CYC`+1). With the default this is E0+12.
- `busy` falls together with the exit from DONE, at E0 + 4·(`SETTLE_CYC`+1) + 1.
- A new vector is driven on the same edge that leaves CHECK. `dut_y` is therefore sampled no earlier than `SETTLE_CYC` cycles after its inputs changed.
- `dut_y` is assumed combinational from `dut_a`/`dut_b`. There is no input synchronizer.

## Structure
- The package `gate_pkg` holds the following:
  - the `op_sel` encodings: BUF=0, NOT=1, AND=2, OR=3, NAND=4, NOR=5, XOR=6, XNOR=7;
  - the state enum: IDLE, SETTLE, CHECK, DONE;
  - the function `golden(op, a, b)`. BUF returns a and NOT returns ~a.
- One sub-module, `gate_golden`, holds the combinational reference model. It is also reused by the bench scoreboard.

## Test plan
- `op_sel`=NOT with a correct `logic_not` model, pulse `start`:
  - `done` is seen at E0+12 (`SETTLE_CYC`=2);
  - `pass`=1, `pass_count`=4, `fail_count`=0, `first_fail`=0.
- `op_sel`=NOT with `dut_y` stuck at 0:
  - `fail_count`=2 (vec 0 and vec 2), `pass_count`=2, `first_fail`=0, `pass`=0.
- `op_sel`=XOR with an OR model connected:
  - `fail_count`=1, `first_fail`=3, `pass_count`=3.
- Assert `rst` during CHECK of vec 1:
  - the next cycle shows IDLE with all outputs 0;
  - a new `start` gives a clean 4/0 result.
- Pulse `start` again at E0+5, and change `op_sel` mid-sweep:
  - the pulse is ignored and the sweep completes on the latched op;
  - `done` is still at E0+12;
  - exactly one `done` pulse occurs.
- `SETTLE_CYC`=1, `op_sel`=NAND, correct model:
  - `done` is seen at E0+8 and `pass`=1.
